// File: rtl/asrv32_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : asrv32_mem_arbiter                                              |
// | Brief    : Shares one memory port between fetch (I) and load/store (D)     |
// |            requesters, one access at a time, round-robin on ties, with a   |
// |            watchdog that aborts stalled accesses.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module asrv32_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH-1:0] i_i_addr,
    output logic                  o_i_ack,
    output logic                  o_i_err,
    output logic [31:0]           o_i_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [31:0]           i_d_wdata,
    input  logic [3:0]            i_d_wsel,
    output logic                  o_d_ack,
    output logic                  o_d_err,
    output logic [31:0]           o_d_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_wsel,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata
);

    localparam int                  c_WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic                c_WDOG_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_d;
    logic [c_WDOG_W-1:0] r_wdog;

    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy;
    logic w_ack_hit;
    logic w_timeout;
    logic w_done;

    always_comb begin
        // A requester whose ack is on the bus this cycle is still holding a stale req.
        w_i_elig    = i_i_req & ~o_i_ack;
        w_d_elig    = i_d_req & ~o_d_ack;
        w_busy      = (r_state != ST_IDLE);
        w_ack_hit   = w_busy & i_mem_ack;
        w_timeout   = w_busy & ~i_mem_ack & c_WDOG_EN & (r_wdog == c_WDOG_LAST);
        w_done      = w_ack_hit | w_timeout;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_d_elig && (!w_i_elig || !r_last_d)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_BUSY_D;
                end else if (w_i_elig) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_d    <= 1'b0;
            r_wdog      <= '0;
            o_i_ack     <= 1'b0;
            o_i_err     <= 1'b0;
            o_i_rdata   <= '0;
            o_d_ack     <= 1'b0;
            o_d_err     <= 1'b0;
            o_d_rdata   <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wsel  <= '0;
        end else begin
            o_i_ack <= 1'b0;
            o_i_err <= 1'b0;
            o_d_ack <= 1'b0;
            o_d_err <= 1'b0;
            if (w_grant_d) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_d_we;
                o_mem_addr  <= i_d_addr;
                o_mem_wdata <= i_d_wdata;
                o_mem_wsel  <= i_d_wsel;
                r_last_d    <= 1'b1;
            end else if (w_grant_i) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_i_addr;
                o_mem_wdata <= '0;
                o_mem_wsel  <= 4'b0000;
                r_last_d    <= 1'b0;
            end
            if (w_done) begin
                // A real ack beats a coincident watchdog expiry.
                o_mem_req <= 1'b0;
                r_wdog    <= '0;
                if (r_state == ST_BUSY_I) begin
                    o_i_ack   <= 1'b1;
                    o_i_err   <= ~w_ack_hit;
                    o_i_rdata <= w_ack_hit ? i_mem_rdata : 32'h0;
                end else begin
                    o_d_ack   <= 1'b1;
                    o_d_err   <= ~w_ack_hit;
                    o_d_rdata <= w_ack_hit ? i_mem_rdata : 32'h0;
                end
            end else if (w_busy && c_WDOG_EN) begin
                r_wdog <= r_wdog + c_WDOG_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asrv32_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_asrv32_mem_arbiter                                           |
// | Brief    : Directed bench with a transaction-level reference model.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_asrv32_mem_arbiter;

    localparam int c_AW  = 32;
    localparam int c_TMO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [c_AW-1:0]   i_addr = '0, d_addr = '0;
    logic [31:0]       d_wdata = '0, mem_rdata = '0;
    logic [3:0]        d_wsel = '0;
    logic              i_ack, i_err, d_ack, d_err, mem_req, mem_we;
    logic [31:0]       i_rdata, d_rdata, mem_wdata;
    logic [c_AW-1:0]   mem_addr;
    logic [3:0]        mem_wsel;

    always #5 clk = ~clk;

    asrv32_mem_arbiter #(.ADDR_WIDTH(c_AW), .TIMEOUT_CYCLES(c_TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_err(i_err), .o_i_rdata(i_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_wsel(d_wsel),
        .o_d_ack(d_ack), .o_d_err(d_err), .o_d_rdata(d_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_wsel(mem_wsel), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requesters and memory responder ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wsel;
    } dreq_t;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    int          mem_wait = 0;
    bit          mem_en = 1'b1;
    bit          spur = 1'b0;
    logic [31:0] next_rdata = 32'h0;
    int          wcnt = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    // Requesters keep req high while their queue is non-empty, so a queued
    // follow-up request is visible during the ack cycle of the previous one.
    always @(posedge clk) begin
        #2;
        if (i_ack && iq.size() > 0) void'(iq.pop_front());
        if (d_ack && dq.size() > 0) void'(dq.pop_front());
        i_req  = (iq.size() > 0);
        i_addr = (iq.size() > 0) ? iq[0] : '0;
        d_req  = (dq.size() > 0);
        if (dq.size() > 0) begin
            d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata; d_wsel = dq[0].wsel;
        end else begin
            d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wsel = '0;
        end
        if (mem_req && mem_en) begin
            if (wcnt >= mem_wait) begin
                mem_ack    = 1'b1;
                mem_rdata  = next_rdata;
                next_rdata = {next_rdata[30:0], next_rdata[31]} ^ 32'h0000_0505;
                wcnt       = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            mem_ack   = spur;
            mem_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
            wcnt      = 0;
        end
    end

    // ---------------- reference model ----------------
    // Tracks the transaction in service (owner, cycles served) and the
    // ack/err pulses it must produce; outputs are what must be seen next cycle.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    int          m_served = 0;
    bit          m_last_d = 1'b0;
    bit          m_valid = 1'b0;
    logic        e_mem_req, e_mem_we, e_i_ack, e_i_err, e_d_ack, e_d_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_i_rdata, e_d_rdata;
    logic [3:0]  e_mem_wsel;
    bit          n_i_ack, n_d_ack, n_err, want_i, want_d, fin;
    int          winner;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1; m_owner = 0; m_served = 0; m_last_d = 1'b0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_wsel = 0;
            e_i_ack = 0; e_i_err = 0; e_i_rdata = 0; e_d_ack = 0; e_d_err = 0; e_d_rdata = 0;
        end else if (m_valid) begin
            n_i_ack = 0; n_d_ack = 0; n_err = 0; fin = 0;
            if (m_owner != 0) begin
                m_served++;
                if (mem_ack) begin
                    fin = 1;
                end else if (c_TMO != 0 && m_served == c_TMO) begin
                    fin = 1; n_err = 1;
                end
                if (fin) begin
                    if (m_owner == 1) begin
                        n_i_ack = 1; e_i_rdata = n_err ? 32'h0 : mem_rdata;
                    end else begin
                        n_d_ack = 1; e_d_rdata = n_err ? 32'h0 : mem_rdata;
                    end
                    m_owner = 0; e_mem_req = 0;
                end
            end else begin
                want_i = i_req && !e_i_ack;
                want_d = d_req && !e_d_ack;
                winner = 0;
                if (want_i && want_d) winner = m_last_d ? 1 : 2;
                else if (want_d)      winner = 2;
                else if (want_i)      winner = 1;
                if (winner == 2) begin
                    e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata; e_mem_wsel = d_wsel;
                end else if (winner == 1) begin
                    e_mem_we = 0; e_mem_addr = i_addr; e_mem_wdata = 0; e_mem_wsel = 0;
                end
                if (winner != 0) begin
                    m_owner = winner; m_served = 0; m_last_d = (winner == 2); e_mem_req = 1;
                end
            end
            e_i_ack = n_i_ack; e_i_err = n_i_ack & n_err;
            e_d_ack = n_d_ack; e_d_err = n_d_ack & n_err;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("i_port", {i_ack, i_err, i_rdata}, {e_i_ack, e_i_err, e_i_rdata});
            check("d_port", {d_ack, d_err, d_rdata}, {e_d_ack, e_d_err, e_d_rdata});
            check("mem_req", mem_req, e_mem_req);
            if (e_mem_req)
                check("mem_payload", {mem_we, mem_addr, mem_wdata, mem_wsel},
                      {e_mem_we, e_mem_addr, e_mem_wdata, e_mem_wsel});
        end
    end

    // ---------------- monitors used by literal checks ----------------
    int          run = 0, last_run = 0;
    logic        prev_req = 1'b0;
    logic [31:0] grants[$];

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            run++;
            if (prev_req !== 1'b1) grants.push_back(mem_addr);
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        prev_req = mem_req;
    end

    // ---------------- helpers ----------------
    task automatic wait_sig(input string name, input int which, input int budget);
        int n = 0;
        bit hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk); #1;
            case (which)
                0: hit = (i_ack === 1'b1);
                1: hit = (d_ack === 1'b1);
                default: hit = (mem_req === 1'b1);
            endcase
            n++;
        end
        if (!hit) begin
            fails++;
            $display("FAIL %s timeout after %0d cycles (required event never seen)", name, budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || mem_req === 1'b1) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            fails++;
            $display("FAIL drain timeout iq=%0d dq=%0d", iq.size(), dq.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        iq.delete(); dq.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, mem_req, mem_we}, '0);
        check({name, "_bus"}, {mem_addr, mem_wdata, mem_wsel}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;

        // fetch, zero-wait memory
        repeat (2) @(posedge clk);
        #3;
        next_rdata = 32'h0000_0013; mem_wait = 0;
        iq.push_back(32'h100);
        @(posedge clk); #3;
        t0 = cyc;
        wait_sig("fetch_ack", 0, 20);
        check("fetch_latency", 32'(cyc - t0), 32'd2);
        check("fetch_rdata", {i_err, i_rdata}, {1'b0, 32'h0000_0013});
        check("fetch_mem_req_len", 32'(last_run), 32'd1);

        // ties after reset: D, then I, then D again
        do_reset();
        dq.push_back('{1'b1, 32'h200, 32'h11, 4'hF});
        iq.push_back(32'h300);
        wait_sig("tie1_req", 2, 20);
        check("tie1_grant_d", {mem_we, mem_addr}, {1'b1, 32'h200});
        wait_sig("tie1_dack", 1, 20);
        wait_sig("tie1_ireq", 2, 20);
        check("tie1_then_i", {mem_we, mem_addr, mem_wsel}, {1'b0, 32'h300, 4'h0});
        wait_sig("tie1_iack", 0, 20);
        @(posedge clk); #3;
        dq.push_back('{1'b0, 32'h204, 32'h0, 4'h0});
        iq.push_back(32'h304);
        wait_sig("tie3_req", 2, 20);
        check("tie3_grant_d", mem_addr, 32'h204);
        wait_drain(40);

        // store with 3 wait states
        @(posedge clk); #3;
        mem_wait = 3;
        dq.push_back('{1'b1, 32'h400, 32'hDEAD_BEEF, 4'b0011});
        wait_sig("store_req", 2, 20);
        check("store_payload", {mem_we, mem_wdata, mem_wsel}, {1'b1, 32'hDEAD_BEEF, 4'b0011});
        wait_sig("store_ack", 1, 20);
        check("store_mem_req_len", 32'(last_run), 32'd4);
        check("store_err", d_err, 1'b0);
        mem_wait = 0;

        // watchdog expiry on a fetch
        @(posedge clk); #3;
        mem_en = 1'b0;
        iq.push_back(32'h500);
        wait_sig("timeout_ack", 0, 40);
        check("timeout_mem_req_len", 32'(last_run), 32'd8);
        check("timeout_err_rdata", {i_err, i_rdata}, {1'b1, 32'h0});
        mem_en = 1'b1;
        wait_drain(20);

        // reset while a data access is in flight
        @(posedge clk); #3;
        mem_en = 1'b0;
        dq.push_back('{1'b0, 32'h600, 32'h0, 4'h0});
        wait_sig("midreset_req", 2, 20);
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        iq.delete(); dq.delete();
        @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("midreset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        mem_en = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_dack", d_ack, 1'b0);
        @(posedge clk); #3;
        dq.push_back('{1'b0, 32'h604, 32'h0, 4'h0});
        iq.push_back(32'h608);
        wait_sig("midreset_tie", 2, 20);
        check("midreset_tie_grant_d", mem_addr, 32'h604);
        wait_drain(40);

        // back-to-back requesters: stale req in ack cycle yields to the other side
        @(posedge clk); #3;
        grants.delete();
        iq.push_back(32'h700); iq.push_back(32'h704);
        dq.push_back('{1'b0, 32'h800, 32'h0, 4'h0});
        dq.push_back('{1'b1, 32'h804, 32'h55AA, 4'hC});
        wait_drain(60);
        check("alt_grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() == 4)
            check("alt_grant_order", {grants[0], grants[1], grants[2], grants[3]},
                  {32'h800, 32'h700, 32'h804, 32'h704});

        // memory acks while nothing is granted are ignored
        @(posedge clk); #3;
        spur = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("spurious_ack_ignored", {i_ack, d_ack, mem_req}, 3'b000);
        @(posedge clk); #3;
        spur = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
